// File: rtl/boot_loader_if.sv
// Byte-stream and Memory word-write bundle for the boot loader.
//   byte_in/byte_valid/byte_ready : incoming program stream (valid/ready)
//   mem_we/mem_adr/mem_wd         : word-write port into the unified Memory
// master = stream source / memory observer, slave = the loader itself.
interface boot_loader_if;
    logic [7:0]  byte_in;
    logic        byte_valid;
    logic        byte_ready;
    logic        mem_we;
    logic [31:0] mem_adr;
    logic [31:0] mem_wd;

    modport master (
        output byte_in, byte_valid,
        input  byte_ready, mem_we, mem_adr, mem_wd
    );

    modport slave (
        input  byte_in, byte_valid,
        output byte_ready, mem_we, mem_adr, mem_wd
    );
endinterface

// File: rtl/boot_loader.sv
// boot_loader: loads a program image into Memory before releasing the core.
// The stream is a 16-bit big-endian word count N followed by N big-endian
// 32-bit words. Each word is written to BASE_ADDR + 4*index through the
// interface's word-write port. cpu_rst is held high until the whole image
// is in Memory.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   bus          : boot_loader_if.slave (byte stream in, Memory write out)
//   reload       : one-cycle pulse, restarts loading from DONE or ERROR
//   cpu_rst      : core reset, low only in DONE
//   load_done    : image fully written
//   load_error   : header count exceeded MAX_WORDS
//   word_count   : words written so far in the current load
module boot_loader #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned MAX_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    boot_loader_if.slave bus,
    input  logic        reload,
    output logic        cpu_rst,
    output logic        load_done,
    output logic        load_error,
    output logic [15:0] word_count
);

    typedef enum logic [2:0] {
        S_HDR_HI,
        S_HDR_LO,
        S_DATA,
        S_WRITE,
        S_DONE,
        S_ERROR
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] n_q;       // header word count
    logic [1:0]  idx_q;     // byte position inside the current word
    logic [31:0] word_q;    // word being assembled, MSB byte first
    logic [15:0] cnt_q;     // words written
    logic        ready;
    logic        xfer;
    logic [15:0] n_full;    // header value as it will be once HDR_LO is taken
    logic [15:0] cnt_inc;

    // ready is decoded from the registered state only, so no path runs
    // from byte_valid to any output.
    assign ready   = (state_q == S_HDR_HI) || (state_q == S_HDR_LO) || (state_q == S_DATA);
    assign xfer    = bus.byte_valid & ready;
    assign n_full  = {n_q[15:8], bus.byte_in};
    assign cnt_inc = cnt_q + 16'd1;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_HDR_HI;
        else     state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HDR_HI: if (xfer) state_d = S_HDR_LO;
            S_HDR_LO: begin
                if (xfer) begin
                    if (n_full == 16'd0)                  state_d = S_DONE;
                    else if (n_full > 16'(MAX_WORDS))     state_d = S_ERROR;
                    else                                  state_d = S_DATA;
                end
            end
            S_DATA:   if (xfer && idx_q == 2'd3) state_d = S_WRITE;
            S_WRITE:  state_d = (cnt_inc == n_q) ? S_DONE : S_DATA;
            S_DONE:   if (reload) state_d = S_HDR_HI;
            S_ERROR:  if (reload) state_d = S_HDR_HI;
            default:  state_d = S_HDR_HI;
        endcase
    end

    // Datapath: everything is captured on transfer edges only, so byte_in
    // may wander freely while ready is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            n_q    <= 16'd0;
            idx_q  <= 2'd0;
            word_q <= 32'd0;
            cnt_q  <= 16'd0;
        end else begin
            case (state_q)
                S_HDR_HI: if (xfer) n_q[15:8] <= bus.byte_in;
                S_HDR_LO: if (xfer) n_q[7:0]  <= bus.byte_in;
                S_DATA: begin
                    if (xfer) begin
                        word_q <= {word_q[23:0], bus.byte_in};
                        idx_q  <= idx_q + 2'd1;   // wraps to 0 after the 4th byte
                    end
                end
                S_WRITE:  cnt_q <= cnt_inc;
                S_DONE, S_ERROR: begin
                    if (reload) begin
                        n_q    <= 16'd0;
                        idx_q  <= 2'd0;
                        word_q <= 32'd0;
                        cnt_q  <= 16'd0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output decode
    always_comb begin
        bus.byte_ready = ready;
        bus.mem_we     = (state_q == S_WRITE);
        cpu_rst        = (state_q != S_DONE);
        load_done      = (state_q == S_DONE);
        load_error     = (state_q == S_ERROR);
    end

    // cnt_q never exceeds MAX_WORDS, so the address stays inside Memory.
    assign bus.mem_adr = BASE_ADDR + {14'd0, cnt_q, 2'b00};
    assign bus.mem_wd  = word_q;
    assign word_count  = cnt_q;

endmodule

// File: tb/tb_boot_loader.sv
// Directed bench for boot_loader. Inputs are driven 1 time unit after the
// rising edge; outputs are sampled 1 unit after the edge or on the falling
// edge. A falling-edge monitor records every Memory write for scoreboarding.
module tb_boot_loader;
    logic        clk = 1'b0;
    logic        rst;
    logic        reload;
    logic        cpu_rst, load_done, load_error;
    logic [15:0] word_count;
    int          pass_cnt = 0;
    int          total_cnt = 0;
    logic [31:0] adr_q[$];
    logic [31:0] dat_q[$];

    boot_loader_if bus ();

    boot_loader dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .reload     (reload),
        .cpu_rst    (cpu_rst),
        .load_done  (load_done),
        .load_error (load_error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            adr_q.push_back(bus.mem_adr);
            dat_q.push_back(bus.mem_wd);
        end
    end

    // Present one byte (after an optional idle gap) and return 1 unit after
    // the edge that transferred it. byte_valid is left high.
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit taken = 0;
        int tries = 0;
        repeat (gap) begin
            bus.byte_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.byte_in    = b;
        bus.byte_valid = 1'b1;
        while (!taken) begin
            @(negedge clk);
            if (bus.byte_ready === 1'b1) taken = 1;
            @(posedge clk); #1;
            tries++;
            if (!taken && tries > 64) begin
                total_cnt++;
                $display("FAIL send_timeout: byte %02h never accepted", b);
                taken = 1;
            end
        end
    endtask

    task automatic pulse_reload();
        reload = 1'b1;
        @(posedge clk); #1;
        reload = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.byte_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total_cnt++;
        if ({cpu_rst, bus.byte_ready, bus.mem_we, load_done, load_error} !== 5'b11000)
            $display("FAIL reset_flags: got %05b want 11000",
                     {cpu_rst, bus.byte_ready, bus.mem_we, load_done, load_error});
        else pass_cnt++;
        total_cnt++;
        if ({bus.mem_adr, bus.mem_wd, word_count} !== 80'd0)
            $display("FAIL reset_data: adr %08h wd %08h cnt %0d want 0/0/0",
                     bus.mem_adr, bus.mem_wd, word_count);
        else pass_cnt++;
        rst = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if ({cpu_rst, bus.byte_ready, load_done} !== 3'b110)
            $display("FAIL reset_idle: got %03b want 110", {cpu_rst, bus.byte_ready, load_done});
        else pass_cnt++;
    endtask

    task automatic test_basic();
        logic [7:0] s[10];
        s = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h00};
        adr_q.delete(); dat_q.delete();
        foreach (s[i]) send_byte(s[i], i % 2);
        bus.byte_valid = 1'b0;
        total_cnt++;
        if ({bus.mem_we, cpu_rst} !== 2'b11)
            $display("FAIL basic_2nd_write: we/cpu_rst %02b want 11", {bus.mem_we, cpu_rst});
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({cpu_rst, load_done, bus.byte_ready} !== 3'b010)
            $display("FAIL basic_done: cpu_rst/done/ready %03b want 010",
                     {cpu_rst, load_done, bus.byte_ready});
        else pass_cnt++;
        total_cnt++;
        if (word_count !== 16'd2) $display("FAIL basic_count: got %0d want 2", word_count);
        else pass_cnt++;
        total_cnt++;
        if (adr_q.size() != 2 || adr_q[0] !== 32'h0 || dat_q[0] !== 32'h20080005 ||
            adr_q[1] !== 32'h4 || dat_q[1] !== 32'h8C090000)
            $display("FAIL basic_writes: %0d writes, first %08h@%08h want 2 writes 20080005@0 8C090000@4",
                     adr_q.size(), (dat_q.size() > 0) ? dat_q[0] : 32'hx,
                     (adr_q.size() > 0) ? adr_q[0] : 32'hx);
        else pass_cnt++;
    endtask

    task automatic test_zero();
        pulse_reload();
        total_cnt++;
        if ({cpu_rst, load_done, bus.byte_ready} !== 3'b101 || word_count !== 16'd0)
            $display("FAIL reload_entry: cpu_rst/done/ready %03b cnt %0d want 101 cnt 0",
                     {cpu_rst, load_done, bus.byte_ready}, word_count);
        else pass_cnt++;
        adr_q.delete(); dat_q.delete();
        send_byte(8'h00, 0);
        send_byte(8'h00, 0);
        bus.byte_valid = 1'b0;
        total_cnt++;
        if ({load_done, cpu_rst} !== 2'b10)
            $display("FAIL zero_done: done/cpu_rst %02b want 10", {load_done, cpu_rst});
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if (adr_q.size() != 0) $display("FAIL zero_no_write: got %0d writes want 0", adr_q.size());
        else pass_cnt++;
    endtask

    task automatic test_error();
        logic [7:0] s[6];
        pulse_reload();
        send_byte(8'h00, 0);
        send_byte(8'h41, 0);
        bus.byte_valid = 1'b1;
        bus.byte_in    = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if ({load_error, cpu_rst, bus.byte_ready, load_done} !== 4'b1100)
            $display("FAIL error_state: err/cpu_rst/ready/done %04b want 1100",
                     {load_error, cpu_rst, bus.byte_ready, load_done});
        else pass_cnt++;
        bus.byte_valid = 1'b0;
        pulse_reload();
        total_cnt++;
        if ({load_error, bus.byte_ready} !== 2'b01)
            $display("FAIL error_reload: err/ready %02b want 01", {load_error, bus.byte_ready});
        else pass_cnt++;
        s = '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
        adr_q.delete(); dat_q.delete();
        foreach (s[i]) send_byte(s[i], 0);
        bus.byte_valid = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (!(adr_q.size() == 1 && adr_q[0] === 32'h0 && dat_q[0] === 32'hDEADBEEF) || load_done !== 1'b1)
            $display("FAIL error_recover: %0d writes done=%0b want 1 write DEADBEEF@0 done=1",
                     adr_q.size(), load_done);
        else pass_cnt++;
    endtask

    task automatic test_full();
        logic [7:0]  img[256];
        logic [31:0] exp_w[64];
        int bad = 0;
        int wait_cyc = 0;
        foreach (img[i]) img[i] = 8'($urandom);
        for (int w = 0; w < 64; w++)
            exp_w[w] = {img[4*w], img[4*w+1], img[4*w+2], img[4*w+3]};
        pulse_reload();
        adr_q.delete(); dat_q.delete();
        send_byte(8'h00, 0);
        send_byte(8'h40, 1);
        foreach (img[i]) send_byte(img[i], ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 3)) : 0);
        bus.byte_valid = 1'b0;
        while (load_done !== 1'b1 && wait_cyc < 8) begin
            @(posedge clk); #1;
            wait_cyc++;
        end
        total_cnt++;
        if (load_done !== 1'b1 || word_count !== 16'd64)
            $display("FAIL full_done: done=%0b cnt=%0d want 1/64", load_done, word_count);
        else pass_cnt++;
        if (adr_q.size() != 64) bad = 64;
        else for (int w = 0; w < 64; w++)
            if (adr_q[w] !== 32'(4 * w) || dat_q[w] !== exp_w[w]) bad++;
        total_cnt++;
        if (bad != 0) $display("FAIL full_scoreboard: %0d bad of %0d writes, want 0 bad of 64", bad, adr_q.size());
        else pass_cnt++;
        total_cnt++;
        if (adr_q.size() == 0 || adr_q[adr_q.size()-1] !== 32'hFC)
            $display("FAIL full_last_adr: got %08h want 000000FC",
                     (adr_q.size() > 0) ? adr_q[adr_q.size()-1] : 32'hx);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        logic [7:0] s[8];
        logic [7:0] f[6];
        s = '{8'h00, 8'h02, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2};
        pulse_reload();
        foreach (s[i]) send_byte(s[i], 0);
        bus.byte_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        total_cnt++;
        if ({cpu_rst, bus.byte_ready, bus.mem_we, load_done, load_error} !== 5'b11000 ||
            bus.mem_adr !== 32'h0 || bus.mem_wd !== 32'h0 || word_count !== 16'd0)
            $display("FAIL midrst_outputs: flags %05b adr %08h wd %08h cnt %0d want 11000/0/0/0",
                     {cpu_rst, bus.byte_ready, bus.mem_we, load_done, load_error},
                     bus.mem_adr, bus.mem_wd, word_count);
        else pass_cnt++;
        @(posedge clk); #1;
        rst = 1'b0;
        f = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        adr_q.delete(); dat_q.delete();
        foreach (f[i]) send_byte(f[i], 0);
        bus.byte_valid = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (!(adr_q.size() == 1 && adr_q[0] === 32'h0 && dat_q[0] === 32'h11223344) || load_done !== 1'b1)
            $display("FAIL midrst_fresh: %0d writes first %08h done=%0b want 1 write 11223344@0 done=1",
                     adr_q.size(), (dat_q.size() > 0) ? dat_q[0] : 32'hx, load_done);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] w0[4];
        logic [7:0] w1[4];
        w0 = '{8'hCA, 8'hFE, 8'hBA, 8'hBE};
        w1 = '{8'h01, 8'h23, 8'h45, 8'h67};
        pulse_reload();
        adr_q.delete(); dat_q.delete();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        foreach (w0[i]) send_byte(w0[i], 0);
        // Now in the WRITE cycle with byte_valid still high; offer junk.
        bus.byte_in = 8'hEE;
        total_cnt++;
        if ({bus.byte_ready, bus.mem_we} !== 2'b01)
            $display("FAIL b2b_write_cycle: ready/we %02b want 01", {bus.byte_ready, bus.mem_we});
        else pass_cnt++;
        @(posedge clk); #1;
        total_cnt++;
        if ({bus.byte_ready, bus.mem_we} !== 2'b10)
            $display("FAIL b2b_after_write: ready/we %02b want 10", {bus.byte_ready, bus.mem_we});
        else pass_cnt++;
        foreach (w1[i]) send_byte(w1[i], 0);
        bus.byte_valid = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if (!(adr_q.size() == 2 && dat_q[0] === 32'hCAFEBABE && dat_q[1] === 32'h01234567 &&
              adr_q[1] === 32'h4) || load_done !== 1'b1)
            $display("FAIL b2b_writes: %0d writes done=%0b want 2 writes CAFEBABE,01234567 done=1",
                     adr_q.size(), load_done);
        else pass_cnt++;
    endtask

    initial begin
        rst = 1'b1;
        reload = 1'b0;
        bus.byte_in = 8'h00;
        bus.byte_valid = 1'b0;
        test_reset();
        test_basic();
        test_zero();
        test_error();
        test_full();
        test_mid_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
